exec_writeback_stage: RTL and testbench

//  Execute stage directly upstream/downstream of the register file: takes a decoded op with valid/ready,

---
 rtl/exec_writeback_stage.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_exec_writeback_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_writeback_stage.sv
// -----------------------------------------------------------------------------
// exec_writeback_stage
//   Execute stage that sits between the decoder and the register file. It
//   accepts one decoded op per cycle (valid/ready), reads both operands through
//   the register-file read ports, computes the ALU result and drives the
//   register-file write port for exactly one cycle per result. A write-back
//   bypass forwards the result being written this cycle to a dependent op that
//   is accepted in the same cycle.
//
//   Optional feature: define MUL_EN to add opcode 8, an unsigned shift-add
//   multiply that takes DATA_WIDTH cycles. Without MUL_EN, opcode 8 is a NOP.
//
// Ports
//   clk, rst              clock (rising edge) / asynchronous active-high reset
//   in_valid, in_ready    op handshake (accept = in_valid && in_ready)
//   in_op, in_rs1, in_rs2 opcode and source registers
//   in_rd                 destination register (r0 is never written)
//   in_use_imm, in_imm    select / value of the immediate operand B
//   rf_reg1, rf_reg2      register-file read indices (= in_rs1 / in_rs2)
//   rf_data1, rf_data2    register-file read data
//   rf_write_en, rf_regw, rf_dataw   register-file write port (registered)
//   busy                  stage is not idle
//   flag_zero, flag_carry flags of the most recent write-back
// -----------------------------------------------------------------------------
module exec_writeback_stage #(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_WIDTH-1:0]       in_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_use_imm,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  output logic [REG_ADDR_WIDTH-1:0] rf_reg1,
  output logic [REG_ADDR_WIDTH-1:0] rf_reg2,
  input  logic [DATA_WIDTH-1:0]     rf_data1,
  input  logic [DATA_WIDTH-1:0]     rf_data2,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_regw,
  output logic [DATA_WIDTH-1:0]     rf_dataw,
  output logic                      busy,
  output logic                      flag_zero,
  output logic                      flag_carry
);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_MOV = OP_WIDTH'(7);

  localparam logic [REG_ADDR_WIDTH-1:0] R_ZERO = {REG_ADDR_WIDTH{1'b0}};

`ifdef MUL_EN
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(8);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_MUL  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1
  } state_t;
`endif

  // Registered state
  state_t                      state_q, state_d;
  logic                        wen_q, wen_d;
  logic [REG_ADDR_WIDTH-1:0]   regw_q, regw_d;
  logic [DATA_WIDTH-1:0]       dataw_q, dataw_d;
  logic                        zero_q, zero_d;
  logic                        carry_q, carry_d;

`ifdef MUL_EN
  logic [2*DATA_WIDTH-1:0]     mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0]   mrd_q, mrd_d;
  logic [2*DATA_WIDTH-1:0]     acc_next;
  logic                        op_mul;
`endif

  // Combinational datapath
  logic                        byp_a;
  logic                        byp_b;
  logic [DATA_WIDTH-1:0]       opa;
  logic [DATA_WIDTH-1:0]       opb;
  logic [DATA_WIDTH-1:0]       alu_res;
  logic                        alu_carry;
  logic                        op_single;
  logic                        accept;

  assign rf_reg1     = in_rs1;
  assign rf_reg2     = in_rs2;
  assign rf_write_en = wen_q;
  assign rf_regw     = regw_q;
  assign rf_dataw    = dataw_q;
  assign flag_zero   = zero_q;
  assign flag_carry  = carry_q;
  assign busy        = (state_q != ST_IDLE);
`ifdef MUL_EN
  assign in_ready    = (state_q != ST_MUL);
`else
  assign in_ready    = 1'b1;
`endif
  assign accept      = in_valid && in_ready;

  // Operand selection with write-back bypass: the register file still holds
  // the old value during the write cycle, so forward the value being written.
  always_comb begin
    byp_a = (state_q == ST_WB) && wen_q && (regw_q == in_rs1) && (in_rs1 != R_ZERO);
    byp_b = (state_q == ST_WB) && wen_q && (regw_q == in_rs2) && (in_rs2 != R_ZERO);
    if (byp_a) begin
      opa = dataw_q;
    end else begin
      opa = rf_data1;
    end
    // The immediate is a literal operand and never takes the bypass.
    if (in_use_imm) begin
      opb = in_imm;
    end else if (byp_b) begin
      opb = dataw_q;
    end else begin
      opb = rf_data2;
    end
  end

  // Single-cycle ALU and opcode classification
  always_comb begin
    alu_res   = {DATA_WIDTH{1'b0}};
    alu_carry = 1'b0;
    op_single = 1'b0;
`ifdef MUL_EN
    op_mul    = 1'b0;
`endif
    case (in_op)
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, opa} + {1'b0, opb};
        op_single = 1'b1;
      end
      OP_SUB: begin
        alu_res   = opa - opb;
        alu_carry = (opa < opb);
        op_single = 1'b1;
      end
      OP_AND: begin
        alu_res   = opa & opb;
        op_single = 1'b1;
      end
      OP_OR: begin
        alu_res   = opa | opb;
        op_single = 1'b1;
      end
      OP_XOR: begin
        alu_res   = opa ^ opb;
        op_single = 1'b1;
      end
      OP_SHL: begin
        alu_res   = {opa[DATA_WIDTH-2:0], 1'b0};
        alu_carry = opa[DATA_WIDTH-1];
        op_single = 1'b1;
      end
      OP_SHR: begin
        alu_res   = {1'b0, opa[DATA_WIDTH-1:1]};
        alu_carry = opa[0];
        op_single = 1'b1;
      end
      OP_MOV: begin
        alu_res   = opb;
        op_single = 1'b1;
      end
`ifdef MUL_EN
      OP_MUL: begin
        op_mul = 1'b1;
      end
`endif
      default: begin
        op_single = 1'b0;
      end
    endcase
  end

  // Next-state, write-port and flag logic
  always_comb begin
    state_d  = state_q;
    wen_d    = 1'b0;
    regw_d   = regw_q;
    dataw_d  = dataw_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
`ifdef MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mrd_d    = mrd_q;
    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    if (mplier_q[0]) begin
      acc_next = acc_q + mcand_q;
    end else begin
      acc_next = acc_q;
    end
`endif
    case (state_q)
      ST_IDLE, ST_WB: begin
        if (accept && op_single) begin
          state_d = ST_WB;
          wen_d   = (in_rd != R_ZERO);
          regw_d  = in_rd;
          dataw_d = alu_res;
          zero_d  = (alu_res == {DATA_WIDTH{1'b0}});
          carry_d = alu_carry;
`ifdef MUL_EN
        end else if (accept && op_mul) begin
          state_d  = ST_MUL;
          mcand_d  = {{DATA_WIDTH{1'b0}}, opa};
          mplier_d = opb;
          acc_d    = {(2*DATA_WIDTH){1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          mrd_d    = in_rd;
`endif
        end else begin
          // No accept, or a NOP: nothing to write, flags hold.
          state_d = ST_IDLE;
        end
      end
`ifdef MUL_EN
      ST_MUL: begin
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          // Last step folds straight into the write-back registers.
          state_d = ST_WB;
          wen_d   = (mrd_q != R_ZERO);
          regw_d  = mrd_q;
          dataw_d = acc_next[DATA_WIDTH-1:0];
          zero_d  = (acc_next[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
          carry_d = |acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          acc_d    = acc_next;
          mcand_d  = {mcand_q[2*DATA_WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[DATA_WIDTH-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wen_q    <= 1'b0;
      regw_q   <= R_ZERO;
      dataw_q  <= {DATA_WIDTH{1'b0}};
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef MUL_EN
      mcand_q  <= {(2*DATA_WIDTH){1'b0}};
      mplier_q <= {DATA_WIDTH{1'b0}};
      acc_q    <= {(2*DATA_WIDTH){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      mrd_q    <= R_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      regw_q   <= regw_d;
      dataw_q  <= dataw_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
`ifdef MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mrd_q    <= mrd_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_exec_writeback_stage
//   Directed-vector bench for exec_writeback_stage. A small behavioural
//   register file answers the read ports combinationally and commits writes on
//   the clock edge that ends the write-back cycle, so dependent ops issued
//   back-to-back only get fresh data through the stage's bypass.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_exec_writeback_stage;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_op;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [AW-1:0] in_rd;
  logic          in_use_imm;
  logic [DW-1:0] in_imm;
  logic [AW-1:0] rf_reg1;
  logic [AW-1:0] rf_reg2;
  logic [DW-1:0] rf_data1;
  logic [DW-1:0] rf_data2;
  logic          rf_write_en;
  logic [AW-1:0] rf_regw;
  logic [DW-1:0] rf_dataw;
  logic          busy;
  logic          flag_zero;
  logic          flag_carry;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rf [16];
  logic          pl_en;
  logic [AW-1:0] pl_idx;
  logic [DW-1:0] pl_val;

  exec_writeback_stage #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_write_en(rf_write_en), .rf_regw(rf_regw), .rf_dataw(rf_dataw),
    .busy(busy), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  always #5 clk = ~clk;

  // Register file model: r0 reads zero; preload port for test setup.
  assign rf_data1 = (rf_reg1 == 4'd0) ? 8'h00 : rf[rf_reg1];
  assign rf_data2 = (rf_reg2 == 4'd0) ? 8'h00 : rf[rf_reg2];

  always @(posedge clk) begin
    if (pl_en) begin
      rf[pl_idx] <= pl_val;
    end else if (rf_write_en && (rf_regw != 4'd0)) begin
      rf[rf_regw] <= rf_dataw;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; write lands on the next rising edge.
  task automatic preload(input logic [AW-1:0] idx, input logic [DW-1:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic use_imm, input logic [DW-1:0] imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_use_imm = use_imm;
    in_imm     = imm;
  endtask

  task automatic check_wb(input string tag, input logic wen, input logic [AW-1:0] regw,
                          input logic [DW-1:0] dataw, input logic zero, input logic carry);
    check_eq({tag, "_wen"}, 32'(rf_write_en), 32'(wen));
    if (wen) begin
      check_eq({tag, "_regw"},  32'(rf_regw),  32'(regw));
      check_eq({tag, "_dataw"}, 32'(rf_dataw), 32'(dataw));
    end
    check_eq({tag, "_zero"},  32'(flag_zero),  32'(zero));
    check_eq({tag, "_carry"}, 32'(flag_carry), 32'(carry));
  endtask

  initial begin
    int low_cnt;
    int wen_seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 4'd0;
    in_rs1     = 4'd0;
    in_rs2     = 4'd0;
    in_rd      = 4'd0;
    in_use_imm = 1'b0;
    in_imm     = 8'h00;
    pl_en      = 1'b0;
    pl_idx     = 4'd0;
    pl_val     = 8'h00;

    @(negedge clk);
    check_eq("rst_wen",   32'(rf_write_en), 32'd0);
    check_eq("rst_regw",  32'(rf_regw),     32'd0);
    check_eq("rst_dataw", 32'(rf_dataw),    32'd0);
    check_eq("rst_zero",  32'(flag_zero),   32'd0);
    check_eq("rst_carry", 32'(flag_carry),  32'd0);
    check_eq("rst_busy",  32'(busy),        32'd0);
    check_eq("rst_ready", 32'(in_ready),    32'd1);

    preload(4'd1,  8'h7F);
    preload(4'd2,  8'h01);
    preload(4'd5,  8'hAA);   // stale value; must be bypassed
    preload(4'd8,  8'h05);
    preload(4'd9,  8'h07);
    preload(4'd10, 8'hFF);
    preload(4'd11, 8'h0D);
    preload(4'd12, 8'h0B);
    preload(4'd13, 8'h10);
    preload(4'd15, 8'h02);
    rst = 1'b0;

    // ADD r3 = r1 + r2
    issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h00);
    #1;
    check_eq("rf_reg1", 32'(rf_reg1), 32'd1);
    check_eq("rf_reg2", 32'(rf_reg2), 32'd2);
    @(negedge clk);
    check_wb("add", 1'b1, 4'd3, 8'h80, 1'b0, 1'b0);
    check_eq("add_busy", 32'(busy), 32'd1);

    // ADDI r4 = r10 + 1 (accepted during previous WB)
    issue(4'd0, 4'd10, 4'd0, 4'd4, 1'b1, 8'h01);
    @(negedge clk);
    check_wb("addi", 1'b1, 4'd4, 8'h00, 1'b1, 1'b1);

    // SUB r14 = 0x05 - 0x07
    issue(4'd1, 4'd8, 4'd9, 4'd14, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("sub", 1'b1, 4'd14, 8'hFE, 1'b0, 1'b1);

    // ADD r5 = r2 + r15 = 0x03
    issue(4'd0, 4'd2, 4'd15, 4'd5, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("add_r5", 1'b1, 4'd5, 8'h03, 1'b0, 1'b0);

    // ADD r7 = r2 + r5 : r5 must come from the bypass (0x03, not 0xAA)
    issue(4'd0, 4'd2, 4'd5, 4'd7, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("byp_b", 1'b1, 4'd7, 8'h04, 1'b0, 1'b0);

    // XOR r6 = r5 ^ r5
    issue(4'd4, 4'd5, 4'd5, 4'd6, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("xor", 1'b1, 4'd6, 8'h00, 1'b1, 1'b0);

    // MOV r0 = imm 0x55 : no write, flags updated
    issue(4'd7, 4'd0, 4'd0, 4'd0, 1'b1, 8'h55);
    @(negedge clk);
    check_wb("mov_r0", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    check_eq("mov_r0_busy", 32'(busy), 32'd1);

    // SHL r3 = r10 << 1 ; bypass of r1 as rs1 tested by SHR below is not needed
    issue(4'd5, 4'd10, 4'd0, 4'd3, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("shl", 1'b1, 4'd3, 8'hFE, 1'b0, 1'b1);

    // SHR r3 = r2 >> 1
    issue(4'd6, 4'd2, 4'd0, 4'd3, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("shr", 1'b1, 4'd3, 8'h00, 1'b1, 1'b1);

    // NOP (op 9): no write, flags hold, back to idle
    issue(4'd9, 4'd1, 4'd2, 4'd3, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("nop", 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    check_eq("nop_busy", 32'(busy), 32'd0);

`ifndef MUL_EN
    // Without the multiplier, op 8 behaves as a NOP
    issue(4'd8, 4'd11, 4'd12, 4'd7, 1'b0, 8'h00);
    @(negedge clk);
    check_wb("op8_nop", 1'b0, 4'd0, 8'h00, 1'b1, 1'b1);
    check_eq("op8_busy",  32'(busy),     32'd0);
    check_eq("op8_ready", 32'(in_ready), 32'd1);
`endif

    // AND r3 = r1 & 0x0F ; OR r3 = r8 | 0xF0
    issue(4'd2, 4'd1, 4'd0, 4'd3, 1'b1, 8'h0F);
    @(negedge clk);
    check_wb("and", 1'b1, 4'd3, 8'h0F, 1'b0, 1'b0);
    issue(4'd3, 4'd8, 4'd0, 4'd3, 1'b1, 8'hF0);
    @(negedge clk);
    check_wb("or", 1'b1, 4'd3, 8'hF5, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_wen",  32'(rf_write_en), 32'd0);
    check_eq("idle_busy", 32'(busy),        32'd0);

`ifdef MUL_EN
    // MUL r7 = 0x0D * 0x0B = 0x8F
    issue(4'd8, 4'd11, 4'd12, 4'd7, 1'b0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    low_cnt  = 0;
    wen_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready == 1'b0) low_cnt++;
      if (rf_write_en) wen_seen++;
      if (i < 7) @(negedge clk);
    end
    check_eq("mul_ready_low", 32'(low_cnt),  32'd8);
    check_eq("mul_no_early",  32'(wen_seen), 32'd0);
    @(negedge clk);
    check_wb("mul", 1'b1, 4'd7, 8'h8F, 1'b0, 1'b0);
    check_eq("mul_ready_back", 32'(in_ready), 32'd1);

    // MUL r3 = 0x10 * 0x10 = 0x100 -> 0x00 with carry
    issue(4'd8, 4'd13, 4'd13, 4'd3, 1'b0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_wb("mul_ovf", 1'b1, 4'd3, 8'h00, 1'b1, 1'b1);

    // Reset three cycles into a multiply aborts it
    @(negedge clk);
    issue(4'd8, 4'd11, 4'd12, 4'd9, 1'b0, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy",  32'(busy),     32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wen_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rf_write_en) wen_seen++;
    end
    check_eq("abort_no_wb",   32'(wen_seen), 32'd0);
    check_eq("abort_idle",    32'(busy),     32'd0);
    check_eq("abort_zero",    32'(flag_zero), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
